regfile_decoded_param: RTL and testbench

//  Parametrised register file built on one-hot wordline decoders: 1 write port, NUM_RD registered read ports.

---
 rtl/regfile_decoded_param.sv | 105 ++++++++++
 tb/tb_regfile_decoded_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_decoded_param.sv
// Register file with one-hot wordline decoders, one write port and NUM_RD registered read ports.
// Adds write->read bypass, an optional hardwired-zero R0 and a sequential clear engine.
module regfile_decoded_param #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_id,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_id,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                    state, state_nxt;
  logic [ADDR_W-1:0]         ptr;
  logic [DATA_W-1:0]         regs [NREGS];
  logic [NREGS-1:0]          wl_wr;
  logic                      wr_accept;
  logic [NUM_RD*DATA_W-1:0]  rd_next;

  // A clear request in the same cycle pre-empts the write.
  always_comb begin
    wr_accept = wr_en && (state == IDLE) && !clr_req &&
                !((ZERO_REG != 0) && (wr_id == '0));
    wl_wr = '0;
    if (wr_accept) wl_wr[wr_id] = 1'b1;
  end

  always_comb begin
    logic [ADDR_W-1:0] id;
    logic [NREGS-1:0]  wl;
    logic [DATA_W-1:0] word;
    rd_next = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      id   = rd_id[p*ADDR_W +: ADDR_W];
      wl   = '0;
      wl[id] = 1'b1;
      word = '0;
      for (int k = 0; k < NREGS; k++) begin
        if (wl[k]) word = word | regs[k];
      end
      if ((BYPASS != 0) && wr_accept && (wr_id == id)) word = wr_data;
      if ((ZERO_REG != 0) && (id == '0)) word = '0;
      rd_next[p*DATA_W +: DATA_W] = word;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == CLEAR);
    clr_done  = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: begin
        if (ptr == '1) begin
          clr_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      rd_data  <= '0;
      rd_valid <= '0;
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + 1'b1;
      else if (clr_req)   ptr <= '0;
      for (int k = 0; k < NREGS; k++) begin
        if ((state == CLEAR) && (ptr == ADDR_W'(k))) regs[k] <= '0;
        else if (wl_wr[k])                          regs[k] <= wr_data;
      end
      // Reads are only serviced while idle; a stalled port keeps its last data.
      for (int p = 0; p < NUM_RD; p++) begin
        if ((state == IDLE) && rd_en[p]) begin
          rd_valid[p]                <= 1'b1;
          rd_data[p*DATA_W +: DATA_W] <= rd_next[p*DATA_W +: DATA_W];
        end else begin
          rd_valid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_decoded_param.sv
// Scoreboard bench: a bypassing and a non-bypassing register file driven by shared stimulus,
// each compared cycle by cycle against a reference model.
module tb_regfile_decoded_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_id = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [7:0]  rd_id = '0;
  logic        clr_req = 1'b0;

  logic [31:0] rd_data_bp, rd_data_nb;
  logic [1:0]  rd_valid_bp, rd_valid_nb;
  logic        busy_bp, busy_nb, clr_done_bp, clr_done_nb;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] data_bp;
    logic [31:0] data_nb;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_mem [16];
  logic        m_clear = 1'b0;
  logic [3:0]  m_ptr = '0;
  logic [15:0] m_bp [2];
  logic [15:0] m_nb [2];

  always #5 clk = ~clk;

  regfile_decoded_param #(.ADDR_W(4), .DATA_W(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data_bp), .rd_valid(rd_valid_bp),
    .clr_req(clr_req), .busy(busy_bp), .clr_done(clr_done_bp)
  );

  regfile_decoded_param #(.ADDR_W(4), .DATA_W(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .rd_en(rd_en), .rd_id(rd_id), .rd_data(rd_data_nb), .rd_valid(rd_valid_nb),
    .clr_req(clr_req), .busy(busy_nb), .clr_done(clr_done_nb)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, predict the registered outputs, then compare after the edge.
  task automatic applyStimulus(input string tag, input logic r, input logic we,
                               input logic [3:0] wid, input logic [15:0] wd,
                               input logic [1:0] re, input logic [3:0] id0,
                               input logic [3:0] id1, input logic clr);
    exp_t       e;
    logic       acc;
    logic [3:0] ids [2];
    @(negedge clk);
    rst = r; wr_en = we; wr_id = wid; wr_data = wd;
    rd_en = re; rd_id = {id1, id0}; clr_req = clr;
    ids[0] = id0; ids[1] = id1;
    acc = we && !m_clear && !clr && (wid != 4'd0);
    e.valid = '0;
    for (int p = 0; p < 2; p++) begin
      if (r) begin
        m_bp[p] = '0; m_nb[p] = '0;
      end else if (!m_clear && re[p]) begin
        e.valid[p] = 1'b1;
        if (ids[p] == 4'd0) begin
          m_bp[p] = '0; m_nb[p] = '0;
        end else begin
          m_nb[p] = m_mem[ids[p]];
          m_bp[p] = (acc && wid == ids[p]) ? wd : m_mem[ids[p]];
        end
      end
    end
    e.data_bp = {m_bp[1], m_bp[0]};
    e.data_nb = {m_nb[1], m_nb[0]};
    if (r) begin
      for (int k = 0; k < 16; k++) m_mem[k] = '0;
      m_clear = 1'b0; m_ptr = '0;
    end else if (m_clear) begin
      m_mem[m_ptr] = '0;
      if (m_ptr == 4'd15) m_clear = 1'b0;
      m_ptr = m_ptr + 4'd1;
    end else begin
      if (acc) m_mem[wid] = wd;
      if (clr) begin m_clear = 1'b1; m_ptr = '0; end
    end
    e.busy = m_clear;
    e.done = m_clear && (m_ptr == 4'd15);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput({tag, " valid_bp"}, 64'(rd_valid_bp), 64'(e.valid));
    checkOutput({tag, " valid_nb"}, 64'(rd_valid_nb), 64'(e.valid));
    checkOutput({tag, " data_bp"}, 64'(rd_data_bp), 64'(e.data_bp));
    checkOutput({tag, " data_nb"}, 64'(rd_data_nb), 64'(e.data_nb));
    checkOutput({tag, " busy/done_bp"}, 64'({busy_bp, clr_done_bp}), 64'({e.busy, e.done}));
    checkOutput({tag, " busy/done_nb"}, 64'({busy_nb, clr_done_nb}), 64'({e.busy, e.done}));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] a, b, w;
    applyStimulus("reset", 1, 0, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus("reset2", 1, 1, 4'd3, 16'h1111, 2'b11, 3, 3, 1);

    applyStimulus("wr_r3", 0, 1, 4'd3, 16'hBEEF, 2'b00, 0, 0, 0);
    applyStimulus("rd_r3", 0, 0, 0, 0, 2'b01, 4'd3, 0, 0);

    applyStimulus("wr_r5_old", 0, 1, 4'd5, 16'h0001, 2'b00, 0, 0, 0);
    applyStimulus("bypass_r5", 0, 1, 4'd5, 16'h1234, 2'b11, 4'd5, 4'd5, 0);
    applyStimulus("rd_r5_after", 0, 0, 0, 0, 2'b11, 4'd5, 4'd5, 0);

    applyStimulus("wr_r0", 0, 1, 4'd0, 16'hFFFF, 2'b11, 4'd0, 4'd0, 0);
    applyStimulus("rd_r0", 0, 0, 0, 0, 2'b11, 4'd0, 4'd0, 0);

    for (int i = 1; i < 16; i++)
      applyStimulus("fill", 0, 1, 4'(i), 16'(i * 16'h1111), 2'b00, 0, 0, 0);
    applyStimulus("rd_fill", 0, 0, 0, 0, 2'b11, 4'd1, 4'd15, 0);
    applyStimulus("clr_req", 0, 0, 0, 0, 2'b11, 4'd2, 4'd14, 1);
    for (int i = 0; i < 16; i++)
      applyStimulus("clearing", 0, 1, 4'd9, 16'h5555, 2'b11, 4'd9, 4'd9, (i == 3));
    for (int i = 0; i < 8; i++)
      applyStimulus("rd_all", 0, 0, 0, 0, 2'b11, 4'(2 * i), 4'(2 * i + 1), 0);

    applyStimulus("wr_r7", 0, 1, 4'd7, 16'h7777, 2'b00, 0, 0, 0);
    applyStimulus("clr_vs_wr", 0, 1, 4'd7, 16'hAAAA, 2'b11, 4'd7, 4'd7, 1);
    for (int i = 0; i < 16; i++)
      applyStimulus("clearing2", 0, 0, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus("rd_r7", 0, 0, 0, 0, 2'b11, 4'd7, 4'd5, 0);

    for (int i = 1; i < 16; i++)
      applyStimulus("refill", 0, 1, 4'(i), 16'(i * 16'h0101), 2'b00, 0, 0, 0);
    applyStimulus("clr_req3", 0, 0, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus("busy3", 0, 0, 0, 0, 2'b00, 0, 0, 0);
    applyStimulus("rst_in_clear", 1, 1, 4'd4, 16'h4444, 2'b11, 4'd4, 4'd4, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus("rd_after_rst", 0, 0, 0, 0, 2'b11, 4'(2 * i), 4'(2 * i + 1), 0);

    applyStimulus("wr_ff", 0, 1, 4'd6, 16'h00FF, 2'b00, 0, 0, 0);
    applyStimulus("rd_ff", 0, 0, 0, 0, 2'b11, 4'd6, 4'd6, 0);
    applyStimulus("hold_ff", 0, 1, 4'd6, 16'h0F0F, 2'b00, 4'd6, 4'd6, 0);

    for (int i = 0; i < 300; i++) begin
      w = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 2) == 0) ? w : 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 2) == 0) ? w : 4'($urandom_range(0, 15));
      applyStimulus("random", ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), w,
                    16'($urandom), 2'($urandom_range(0, 3)), a, b,
                    ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
